// File: rtl/kabeta_mem_pkg.sv
// rtl/kabeta_mem_pkg.sv - shared data-memory widths and port indices
package kabeta_mem_pkg;

   localparam int DMEM_ADDR_W   = 30;
   localparam int DMEM_DATA_W   = 32;
   localparam int STARVE_CNT_W  = 4;
   localparam int DMEM_PORT_CPU = 0;
   localparam int DMEM_PORT_DBG = 1;

   typedef logic [DMEM_ADDR_W-1:0]  dmem_addr_t;
   typedef logic [DMEM_DATA_W-1:0]  dmem_data_t;
   typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - fixed-priority two-port data-memory arbiter with starvation guard
module dmem_arbiter
   import kabeta_mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Req0,
   input  logic       Req1,
   input  logic       We0,
   input  logic       We1,
   input  dmem_addr_t Addr0,
   input  dmem_addr_t Addr1,
   input  dmem_data_t WData0,
   input  dmem_data_t WData1,
   output logic       Ack0,
   output logic       Ack1,
   output logic       RValid0,
   output logic       RValid1,
   output dmem_data_t RData,
   output dmem_addr_t Mem_Addr,
   output logic       Mem_En_W,
   output logic       Mem_En_R,
   output dmem_data_t Mem_Data_W,
   input  dmem_data_t Mem_Data_R
);

   localparam starve_cnt_t LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   starve_cnt_t wait_cnt_q, wait_cnt_d;
   logic [1:0]  rd_port_q, rd_port_d;
   logic        gnt0, gnt1;

   // Port 1 overrides port 0 only once it has lost LIMIT cycles in a row.
   always_comb begin
      gnt1 = Req1 && ((wait_cnt_q == LIMIT) || !Req0);
      gnt0 = Req0 && !gnt1;
   end

   always_comb begin
      Mem_Addr   = Addr0;
      Mem_Data_W = WData0;
      Ack0       = 1'b0;
      Ack1       = 1'b0;
      Mem_En_W   = 1'b0;
      Mem_En_R   = 1'b0;
      if (gnt1) begin
         Mem_Addr   = Addr1;
         Mem_Data_W = WData1;
      end
      if (!Reset) begin
         Ack0     = gnt0;
         Ack1     = gnt1;
         Mem_En_W = (gnt0 && We0) || (gnt1 && We1);
         Mem_En_R = (gnt0 && !We0) || (gnt1 && !We1);
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!Req1 || gnt1) begin
         wait_cnt_d = '0;
      end else if (gnt0 && (wait_cnt_q != LIMIT)) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      rd_port_d = '0;
      rd_port_d[DMEM_PORT_CPU] = gnt0 && !We0;
      rd_port_d[DMEM_PORT_DBG] = gnt1 && !We1;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wait_cnt_q <= '0;
         rd_port_q  <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         rd_port_q  <= rd_port_d;
      end
   end

   assign RValid0 = rd_port_q[DMEM_PORT_CPU] && !Reset;
   assign RValid1 = rd_port_q[DMEM_PORT_DBG] && !Reset;
   assign RData   = Mem_Data_R;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a reference model
module tb_dmem_arbiter;

   localparam int LIMIT = 4;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Req0 = 0, Req1 = 0, We0 = 0, We1 = 0;
   logic [29:0] Addr0 = '0, Addr1 = '0;
   logic [31:0] WData0 = '0, WData1 = '0;
   logic        Ack0, Ack1, RValid0, RValid1, Mem_En_W, Mem_En_R;
   logic [31:0] RData, Mem_Data_W, Mem_Data_R;
   logic [29:0] Mem_Addr;

   dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .Clock(Clock), .Reset(Reset),
      .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
      .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
      .Ack0(Ack0), .Ack1(Ack1), .RValid0(RValid0), .RValid1(RValid1),
      .RData(RData), .Mem_Addr(Mem_Addr), .Mem_En_W(Mem_En_W),
      .Mem_En_R(Mem_En_R), .Mem_Data_W(Mem_Data_W), .Mem_Data_R(Mem_Data_R)
   );

   always #5 Clock = ~Clock;

   // Memory attached to the arbiter: 256 words, one-cycle read latency.
   logic [31:0] mem [256];
   logic [31:0] mem_rd = '0;
   always @(posedge Clock) begin
      if (Mem_En_W) mem[Mem_Addr[7:0]] <= Mem_Data_W;
      if (Mem_En_R) mem_rd <= mem[Mem_Addr[7:0]];
   end
   assign Mem_Data_R = mem_rd;

   // Reference model state.
   logic [31:0] ref_mem [256];
   int          lost;
   logic        exp_rv0, exp_rv1, g0, g1;
   logic [31:0] exp_rdata;
   int          n_cmp = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step(input logic r0, input logic w0, input logic [29:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [29:0] a1, input logic [31:0] d1);
      @(negedge Clock);
      Req0 = r0; We0 = w0; Addr0 = a0; WData0 = d0;
      Req1 = r1; We1 = w1; Addr1 = a1; WData1 = d1;
      #1;
      g1 = r1 && ((lost == LIMIT) || !r0);
      g0 = r0 && !g1;
      check("ack0", Ack0, g0);
      check("ack1", Ack1, g1);
      check("en_w", Mem_En_W, (g0 && w0) || (g1 && w1));
      check("en_r", Mem_En_R, (g0 && !w0) || (g1 && !w1));
      check("addr", Mem_Addr, g1 ? a1 : a0);
      if ((g0 && w0) || (g1 && w1)) check("wdata", Mem_Data_W, g1 ? d1 : d0);
      check("rvalid0", RValid0, exp_rv0);
      check("rvalid1", RValid1, exp_rv1);
      if (exp_rv0 || exp_rv1) check("rdata", RData, exp_rdata);
      exp_rdata = g1 ? ref_mem[a1[7:0]] : ref_mem[a0[7:0]];
      if (g0 && w0) ref_mem[a0[7:0]] = d0;
      if (g1 && w1) ref_mem[a1[7:0]] = d1;
      exp_rv0 = g0 && !w0;
      exp_rv1 = g1 && !w1;
      if (!r1 || g1) lost = 0;
      else if (g0 && lost < LIMIT) lost = lost + 1;
   endtask

   task automatic idle();
      step(0, 0, '0, '0, 0, 0, '0, '0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack0"}, Ack0, 0);
      check({tag, "_ack1"}, Ack1, 0);
      check({tag, "_en_w"}, Mem_En_W, 0);
      check({tag, "_en_r"}, Mem_En_R, 0);
      check({tag, "_rv0"}, RValid0, 0);
      check({tag, "_rv1"}, RValid1, 0);
   endtask

   logic        p0_act, p0_we, p1_act, p1_we;
   logic [29:0] p0_a, p1_a;
   logic [31:0] p0_d, p1_d, tmp;
   logic        p1_done;
   int          p0_n;

   task automatic new_txn(output logic we, output logic [29:0] a, output logic [31:0] d);
      logic [31:0] r;
      r  = $urandom;
      we = ($urandom_range(0, 2) == 0);
      a  = {r[29:28], 23'b0, r[4:0]};
      d  = $urandom;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'hA500_0000 | i;
         ref_mem[i] = 32'hA500_0000 | i;
      end
      lost = 0; exp_rv0 = 0; exp_rv1 = 0; exp_rdata = '0;
      Req0 = 1;
      repeat (3) @(negedge Clock);
      #1 check_reset_outputs("por");
      Req0 = 0;
      Reset = 0;

      // Port 0 write then read
      step(1, 1, 30'h5, 32'hDEADBEEF, 0, 0, '0, '0);
      check("wr5_en_w", Mem_En_W, 1);
      step(1, 0, 30'h5, '0, 0, 0, '0, '0);
      idle();
      check("rd5_rv0", RValid0, 1);
      check("rd5_data", RData, 32'hDEADBEEF);
      check("rd5_rv1", RValid1, 0);

      // Simultaneous reads: port 0 first, port 1 next cycle
      step(1, 0, 30'h1, '0, 1, 0, 30'h2, '0);
      check("sim_ack0", Ack0, 1);
      step(0, 0, '0, '0, 1, 0, 30'h2, '0);
      check("sim_ack1", Ack1, 1);
      check("sim_rd1", RData, 32'hA500_0001);
      idle();
      check("sim_rd2", RData, 32'hA500_0002);

      // Starvation guard
      p1_done = 0; p0_n = 0;
      for (int i = 0; i < 11; i++) begin
         step(p0_n < 10, 0, 30'(8'h80 + p0_n), '0, !p1_done, 0, 30'h40, '0);
         check("stv_ack1", Ack1, i == 4);
         check("stv_ack0", Ack0, i != 4);
         if (Ack1) p1_done = 1;
         if (Ack0) p0_n++;
      end
      idle();

      // Back-to-back port 1 reads
      step(0, 0, '0, '0, 1, 0, 30'h20, '0);
      step(0, 0, '0, '0, 1, 0, 30'h21, '0);
      check("b2b_rd20", RData, 32'hA500_0020);
      step(0, 0, '0, '0, 1, 0, 30'h22, '0);
      check("b2b_rd21", RData, 32'hA500_0021);
      idle();
      check("b2b_rd22", RData, 32'hA500_0022);

      // Withdrawn request, then counter must restart from zero
      for (int i = 0; i < 7; i++) begin
         step(1, 0, 30'h3, '0, i < 2, 0, 30'h4, '0);
         check("wd_ack1", Ack1, 0);
      end
      p1_done = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 30'h3, '0, !p1_done, 0, 30'h4, '0);
         check("wd_late_ack1", Ack1, i == 4);
         if (Ack1) p1_done = 1;
      end
      idle();

      // Reset while a read is outstanding
      step(1, 1, 30'h10, 32'h1234_5678, 0, 0, '0, '0);
      step(1, 0, 30'h10, '0, 0, 0, '0, '0);
      @(negedge Clock);
      Reset = 1;
      #1 check_reset_outputs("rst_mid");
      exp_rv0 = 0; exp_rv1 = 0; lost = 0;
      @(negedge Clock);
      Req0 = 0; Req1 = 0;
      #1 check_reset_outputs("rst_hold");
      Reset = 0;
      step(1, 0, 30'h10, '0, 0, 0, '0, '0);
      idle();
      check("rst_rd10", RData, 32'h1234_5678);

      // Randomized traffic
      p0_act = 0; p1_act = 0;
      p0_we = 0; p1_we = 0; p0_a = '0; p1_a = '0; p0_d = '0; p1_d = '0;
      for (int c = 0; c < 3000; c++) begin
         if (!p0_act && $urandom_range(0, 99) < 50) begin new_txn(p0_we, p0_a, p0_d); p0_act = 1; end
         else if (p0_act && $urandom_range(0, 99) < 3) p0_act = 0;
         if (!p1_act && $urandom_range(0, 99) < 40) begin new_txn(p1_we, p1_a, p1_d); p1_act = 1; end
         else if (p1_act && $urandom_range(0, 99) < 3) p1_act = 0;
         step(p0_act, p0_we, p0_a, p0_d, p1_act, p1_we, p1_a, p1_d);
         if (g0) begin
            if ($urandom_range(0, 99) < 70) new_txn(p0_we, p0_a, p0_d);
            else p0_act = 0;
         end
         if (g1) begin
            if ($urandom_range(0, 99) < 70) new_txn(p1_we, p1_a, p1_d);
            else p1_act = 0;
         end
      end
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store stage (port 0) and a secondary bus master (port 1: debug/loader DMA). It sits between both requesters and the data-memory wrapper, issues at most one memory access per cycle, and returns read data with a per-port valid strobe. Port 0 has fixed priority, with a starvation guard that forces a port-1 grant after a bounded wait.

## Interface
- STARVE_LIMIT, default 4: consecutive cycles port 1 may wait while port 0 wins; legal range 1..15.
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Req0, Req1  in  1  access request, held until the matching Ack.
- We0, We1  in  1  1 = write, 0 = read; stable while Req high.
- Addr0, Addr1  in  30  word address; stable while Req high.
- WData0, WData1  in  32  write data; stable while Req high.
- Ack0, Ack1  out  1  access issued this cycle.
- RValid0, RValid1  out  1  read data on RData valid this cycle.
- RData  out  32  read data, shared by both ports.
- Mem_Addr  out  30  to memory Addr.
- Mem_En_W, Mem_En_R  out  1  to memory En_W / En_R.
- Mem_Data_W  out  32  to memory Data_W.
- Mem_Data_R  in  32  from memory Data_R, valid 1 cycle after En_R.

## Operation
- Grant decision is combinational each cycle from Req0, Req1 and the wait counter:
  - Req1 and WaitCnt == STARVE_LIMIT: grant port 1.
  - else Req0: grant port 0.
  - else Req1: grant port 1.
  - else: no grant; Mem_En_W = Mem_En_R = 0.
- The granted port's Addr/WData drive Mem_Addr/Mem_Data_W. Mem_En_W = We, Mem_En_R = !We. Ack of the granted port is 1 the same cycle.
- With no grant, Mem_Addr and Mem_Data_W hold port 0's values. Ports are don't-care, but the enables must be 0.
- WaitCnt (4 bits, registered):
  - clears when Req1 is low or port 1 is granted.
  - increments when Req1 is high and port 0 is granted.
  - saturates at STARVE_LIMIT.
- Read-return register RdPort (2 bits, one-hot: {port1, port0}) is loaded each cycle with the read grant, 0 for writes or idle. RValidN = RdPort[N]; RData = Mem_Data_R passed through.
- A requester holding Req after its Ack issues a new access (back-to-back allowed, one per cycle).
- Dropping Req before Ack is legal: no access occurs.

## Timing
- Reset values: Ack0/1 = 0, Mem_En_W/R = 0, RValid0/1 = 0, WaitCnt = 0, RdPort = 0.
- While Reset is high, outputs are forced to those values regardless of Req.
- Issue latency: 0 cycles from Req to Ack/enable when the port wins.
- Read latency: cycle N Ack with We = 0 -> cycle N+1 RValid = 1, RData = mem[Addr].
- Write completes at the cycle N clock edge; no RValid.
- Pipelined reads: a grant every cycle yields RValid every cycle, tagged to the correct port.
- Port 1 worst-case wait with port 0 continuously requesting: STARVE_LIMIT cycles, granted on cycle STARVE_LIMIT+1.
- Port 0 is then stalled exactly one cycle.
- Reset asserted while a read is outstanding: RValid for that read is suppressed (RdPort cleared asynchronously).

## Structure
- Shared package kabeta_mem_pkg:
  - DMEM_ADDR_W = 30, DMEM_DATA_W = 32.
  - STARVE_CNT_W = 4.
  - Port index constants DMEM_PORT_CPU = 0, DMEM_PORT_DBG = 1.
- Single flat module; no sub-module. The wait counter and return register are too small to split out.
- Instantiated in the top level between the CPU memory stage, the debug master and the existing data-memory wrapper.

## Test plan
- Reset mid-read:
  - Port 0 read Addr 0x10 issued, Reset pulsed in the following cycle.
  - RValid0 stays 0.
  - All outputs return to their reset values.
  - After release, a read of Addr 0x10 returns correctly.
- Single port 0 write then read:
  - Write 0xDEADBEEF at Addr 0x5 -> Ack0 same cycle, Mem_En_W = 1.
  - Read Addr 0x5 -> Ack0, then next cycle RValid0 = 1, RData = 0xDEADBEEF, RValid1 = 0.
- Simultaneous requests, no starvation:
  - Req0 (read 0x1) and Req1 (read 0x2) in the same cycle.
  - Ack0 first. Ack1 the next cycle.
  - RValid0 and RValid1 in consecutive cycles with the correct data.
- Starvation guard, STARVE_LIMIT = 4:
  - Req0 held continuously for 10 reads; Req1 asserted at cycle 0.
  - Ack0 in cycles 0–3, Ack1 in cycle 4, Ack0 resumes in cycle 5.
  - WaitCnt is 0 after cycle 4.
- Back-to-back port 1 reads:
  - Req1 held for 3 accesses at Addr 0x20, 0x21, 0x22.
  - Three consecutive Acks.
  - RValid1 high for 3 cycles starting one cycle later, data in order.
- Request withdrawn:
  - Req1 raised for 2 cycles while port 0 wins, then dropped.
  - No Ack1, no memory access for port 1.
  - WaitCnt returns to 0.
